// File: rtl/keypad_entry.sv
// Keypad entry front-end: builds a BCD HH:MM buffer from one-hot key presses,
// validates it as 24-hour time and strobes a time/alarm load on button commit.
module keypad_entry #(
   parameter int unsigned TIMEOUT = 15360
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  keypad_buttons,
   input  logic        time_button,
   input  logic        alarm_button,
   output logic [15:0] key_value,
   output logic [2:0]  digit_count,
   output logic        entry_active,
   output logic        load_time,
   output logic        load_alarm,
   output logic        entry_error
);

   localparam int unsigned KEY_W = 10;
   localparam int unsigned VAL_W = 16;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned TMR_W = 16;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      ENTRY = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [KEY_W-1:0]   keys_s_q, keys_s_d;
   logic [KEY_W-1:0]   keys_p_q, keys_p_d;
   logic               time_s_q, time_s_d;
   logic               time_p_q, time_p_d;
   logic               alarm_s_q, alarm_s_d;
   logic               alarm_p_q, alarm_p_d;
   logic [VAL_W-1:0]   key_value_q, key_value_d;
   logic [CNT_W-1:0]   digit_count_q, digit_count_d;
   logic               entry_active_q, entry_active_d;
   logic               load_time_q, load_time_d;
   logic               load_alarm_q, load_alarm_d;
   logic               entry_error_q, entry_error_d;
   logic [TMR_W-1:0]   timer_q, timer_d;

   logic               key_edge;
   logic               time_edge;
   logic               alarm_edge;
   logic               time_valid;
   logic [3:0]         key_digit;

   // State and input-sample registers; edge detectors reset to "held"
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         keys_s_q       <= '1;
         keys_p_q       <= '1;
         time_s_q       <= 1'b1;
         time_p_q       <= 1'b1;
         alarm_s_q      <= 1'b1;
         alarm_p_q      <= 1'b1;
         key_value_q    <= '0;
         digit_count_q  <= '0;
         entry_active_q <= 1'b0;
         load_time_q    <= 1'b0;
         load_alarm_q   <= 1'b0;
         entry_error_q  <= 1'b0;
         timer_q        <= '0;
      end else begin
         state_q        <= state_d;
         keys_s_q       <= keys_s_d;
         keys_p_q       <= keys_p_d;
         time_s_q       <= time_s_d;
         time_p_q       <= time_p_d;
         alarm_s_q      <= alarm_s_d;
         alarm_p_q      <= alarm_p_d;
         key_value_q    <= key_value_d;
         digit_count_q  <= digit_count_d;
         entry_active_q <= entry_active_d;
         load_time_q    <= load_time_d;
         load_alarm_q   <= load_alarm_d;
         entry_error_q  <= entry_error_d;
         timer_q        <= timer_d;
      end
   end

   // Next-state: button commit beats key accept, key accept beats timeout
   always_comb begin
      state_d        = state_q;
      keys_s_d       = keypad_buttons;
      keys_p_d       = keys_s_q;
      time_s_d       = time_button;
      time_p_d       = time_s_q;
      alarm_s_d      = alarm_button;
      alarm_p_d      = alarm_s_q;
      key_value_d    = key_value_q;
      digit_count_d  = digit_count_q;
      entry_active_d = entry_active_q;
      load_time_d    = 1'b0;
      load_alarm_d   = 1'b0;
      entry_error_d  = 1'b0;
      timer_d        = timer_q;
      key_digit      = 4'd0;

      for (int i = 0; i < int'(KEY_W); i++) begin
         if (keys_s_q[i]) key_digit = 4'(i);
      end

      key_edge   = (keys_p_q == '0) && $onehot(keys_s_q);
      time_edge  = time_s_q & ~time_p_q;
      alarm_edge = alarm_s_q & ~alarm_p_q;

      time_valid = (key_value_q[15:12] <= 4'd2) &&
                   (key_value_q[11:8]  <= 4'd9) &&
                   ((key_value_q[15:12] != 4'd2) || (key_value_q[11:8] <= 4'd3)) &&
                   (key_value_q[7:4]   <= 4'd5) &&
                   (key_value_q[3:0]   <= 4'd9);

      if (time_edge || alarm_edge) begin
         if (digit_count_q != 3'd0) begin
            if ((digit_count_q == 3'd4) && time_valid) begin
               load_time_d  = time_edge;
               load_alarm_d = ~time_edge;
            end else begin
               entry_error_d = 1'b1;
            end
         end
         digit_count_d = 3'd0;
         timer_d       = '0;
      end else if (key_edge) begin
         if (digit_count_q == 3'd4) begin
            key_value_d   = {12'h000, key_digit};
            digit_count_d = 3'd1;
         end else begin
            key_value_d   = {key_value_q[11:0], key_digit};
            digit_count_d = digit_count_q + 3'd1;
         end
         timer_d = '0;
      end else if (state_q == ENTRY) begin
         if (timer_q == TMR_LAST) begin
            digit_count_d = 3'd0;
            timer_d       = '0;
         end else if (timer_q != '1) begin
            timer_d = timer_q + 16'd1;
         end
      end else begin
         timer_d = '0;
      end

      state_d        = (digit_count_d == 3'd0) ? IDLE : ENTRY;
      entry_active_d = (digit_count_d != 3'd0);
   end

   assign key_value    = key_value_q;
   assign digit_count  = digit_count_q;
   assign entry_active = entry_active_q;
   assign load_time    = load_time_q;
   assign load_alarm   = load_alarm_q;
   assign entry_error  = entry_error_q;

endmodule
